// File: rtl/handshake_const_rr_arbiter.sv
// Round-robin arbiter that issues one per-requester constant per cycle via a one-slot output register.
// Optional issue counter port enabled by defining HS_CONST_ARB_CNT_EN.
module handshake_const_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [N_REQ*DATA_WIDTH-1:0] CONST_TABLE = {32'h44, 32'h33, 32'h22, 32'h11},
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      ctrl_valid,
   output logic [N_REQ-1:0]      ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic [IDX_W-1:0]      outs_idx,
   output logic                  outs_valid,
`ifdef HS_CONST_ARB_CNT_EN
   input  logic                  outs_ready,
   output logic [15:0]           issue_cnt
`else
   input  logic                  outs_ready
`endif
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] outs_q, outs_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

   logic [DATA_WIDTH-1:0] const_rom [N_REQ];
   logic                  accept;
   logic                  grant_found;
   logic [IDX_W-1:0]      grant_idx;
   logic                  hs;
   int unsigned           cand;

   for (genvar i = 0; i < N_REQ; i++) begin : g_rom
      assign const_rom[i] = CONST_TABLE[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!grant_found && ctrl_valid[IDX_W'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   // No token is taken while reset is asserted, so it cannot be lost.
   assign accept = (state_q == StEmpty) || outs_ready;
   assign hs     = rst && accept && grant_found;

   always_comb begin
      ctrl_ready = '0;
      if (hs) ctrl_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StEmpty;
         outs_q   <= '0;
         idx_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         outs_q   <= outs_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      outs_d   = outs_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      if (hs) begin
         state_d  = StFull;
         outs_d   = const_rom[grant_idx];
         idx_d    = grant_idx;
         rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end else if (outs_ready) begin
         state_d = StEmpty;
      end
   end

   always_comb begin
      outs_valid = (state_q == StFull);
      outs       = outs_q;
      outs_idx   = idx_q;
   end

`ifdef HS_CONST_ARB_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (hs && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign issue_cnt = cnt_q;
`endif

endmodule
